macro_fifo4_incr2: RTL and testbench

- 4-entry, single-clock, first-word-fall-through FIFO for short decoupling queues.
- Intended for the Taurus 3001 pipeline, e.g. between the fetch buffer and decode.
- Read and write pointers are 2-bit indices plus a wrap bit.
- Each pointer advances through the sub-module macro_rom_incr2, a 2-bit unsigned increment ROM with carry-out. It is the increment counterpart of the existing 2-bit decrement ROM.

---
 rtl/macro_fifo4_incr2_pkg.sv | 7 +
 rtl/macro_rom_incr2.sv | 19 +
 rtl/macro_fifo4_incr2.sv | 89 ++++++++
 tb/tb_macro_fifo4_incr2.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/macro_fifo4_incr2_pkg.sv
// Shared sizing for the 4-entry FWFT FIFO: pointer, depth and occupancy widths.
// Depth is fixed by the 2-bit pointer; occupancy needs one extra bit to reach 4.
package macro_fifo4_incr2_pkg;
    localparam int PTR_W = 2;
    localparam int DEPTH = 1 << PTR_W;
    localparam int CNT_W = PTR_W + 1;
endpackage

// File: rtl/macro_rom_incr2.sv
// 2-bit unsigned increment ROM with carry-out; drop-in for "+1" on 2-bit fields.
// Purely combinational; carry is set only on the 3->0 wrap.
module macro_rom_incr2 (
    input  logic [1:0] d,
    output logic [1:0] q,
    output logic       c
);
    always_comb begin
        q = 2'd0;
        c = 1'b0;
        case (d)
            2'd0: begin q = 2'd1; c = 1'b0; end
            2'd1: begin q = 2'd2; c = 1'b0; end
            2'd2: begin q = 2'd3; c = 1'b0; end
            2'd3: begin q = 2'd0; c = 1'b1; end
            default: begin q = 2'd0; c = 1'b0; end
        endcase
    end
endmodule

// File: rtl/macro_fifo4_incr2.sv
// 4-entry single-clock first-word-fall-through FIFO; rdata is the head, combinational from storage.
// Push visible one cycle after its edge; wready/rvalid depend on registers only, never on wen/ren.
module macro_fifo4_incr2
    import macro_fifo4_incr2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    output logic             wready,
    input  logic             ren,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);
    logic [PTR_W-1:0] r_wptr;
    logic             r_wwrap;
    logic [PTR_W-1:0] r_rptr;
    logic             r_rwrap;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] w_wptr_nxt;
    logic             w_wptr_c;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic             w_rptr_c;
    logic             w_ptr_eq;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    macro_rom_incr2 u_wptr_incr (
        .d (r_wptr),
        .q (w_wptr_nxt),
        .c (w_wptr_c)
    );

    macro_rom_incr2 u_rptr_incr (
        .d (r_rptr),
        .q (w_rptr_nxt),
        .c (w_rptr_c)
    );

    // Equal indices mean empty or full; the wrap bits tell the two apart.
    assign w_ptr_eq = (r_wptr == r_rptr);
    assign w_empty  = w_ptr_eq && (r_wwrap == r_rwrap);
    assign w_full   = w_ptr_eq && (r_wwrap != r_rwrap);

    assign w_push = wen && !w_full;
    assign w_pop  = ren && !w_empty;

    assign wready = !w_full;
    assign rvalid = !w_empty;
    assign rdata  = r_mem[r_rptr];
    assign count  = {r_wwrap ^ r_rwrap, r_wptr} - {1'b0, r_rptr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_wwrap <= 1'b0;
        end else if (w_push) begin
            r_wptr  <= w_wptr_nxt;
            r_wwrap <= r_wwrap ^ w_wptr_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr  <= '0;
            r_rwrap <= 1'b0;
        end else if (w_pop) begin
            r_rptr  <= w_rptr_nxt;
            r_rwrap <= r_rwrap ^ w_rptr_c;
        end
    end

    // Storage is not cleared on pop; only reset zeroes it so rdata is defined when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end
endmodule

// File: tb/tb_macro_fifo4_incr2.sv
// Scoreboard bench for macro_fifo4_incr2: queue reference model, directed phases then random traffic.
// Also sweeps macro_rom_incr2 exhaustively.
module tb_macro_fifo4_incr2;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wen = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       wready;
    logic       ren = 1'b0;
    logic       rvalid;
    logic [7:0] rdata;
    logic [2:0] count;

    logic [1:0] rom_d = 2'd0;
    logic [1:0] rom_q;
    logic       rom_c;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    macro_fifo4_incr2 #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .wen    (wen),
        .wdata  (wdata),
        .wready (wready),
        .ren    (ren),
        .rvalid (rvalid),
        .rdata  (rdata),
        .count  (count)
    );

    macro_rom_incr2 u_rom (
        .d (rom_d),
        .q (rom_q),
        .c (rom_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares flags, occupancy and head word against the model queue, then
    // retires accepted pops and records accepted pushes exactly as the next edge will.
    always @(negedge clk) begin
        if (!reset) begin
            automatic int  sz = exp_q.size();
            automatic bit  do_pop  = ren && (sz > 0);
            automatic bit  do_push = wen && (sz < 4);
            chk("count",  {29'd0, count}, sz);
            chk("wready", {31'd0, wready}, (sz < 4) ? 1 : 0);
            chk("rvalid", {31'd0, rvalid}, (sz > 0) ? 1 : 0);
            if (sz > 0) chk("rdata_head", {24'd0, rdata}, {24'd0, exp_q[0]});
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(wdata);
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        @(posedge clk);
        #1;
        wen   = w;
        wdata = d;
        ren   = r;
    endtask

    initial begin
        // Reset state, checked while reset is held and after release
        #2;
        chk("rst_held_count",  {29'd0, count}, 0);
        chk("rst_held_rvalid", {31'd0, rvalid}, 0);
        chk("rst_held_wready", {31'd0, wready}, 1);
        chk("rst_held_rdata",  {24'd0, rdata}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("idle_rdata", {24'd0, rdata}, 0);

        // Reset mid-stream with 3 entries held takes effect without a clock edge
        step(1, 8'hA1, 0);
        step(1, 8'hA2, 0);
        step(1, 8'hA3, 0);
        step(0, 8'h00, 0);
        @(negedge clk);
        chk("pre_rst_count", {29'd0, count}, 3);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_count",  {29'd0, count}, 0);
        chk("mid_rst_rvalid", {31'd0, rvalid}, 0);
        chk("mid_rst_wready", {31'd0, wready}, 1);
        chk("mid_rst_rdata",  {24'd0, rdata}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fill to full, then a 5th push that must be ignored
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        step(1, 8'h44, 0);
        step(1, 8'h55, 0);
        step(0, 8'h00, 0);
        @(negedge clk);
        chk("full_count",  {29'd0, count}, 4);
        chk("full_wready", {31'd0, wready}, 0);

        // Drain in order, then one extra ren on empty
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        @(negedge clk);
        chk("drained_rvalid", {31'd0, rvalid}, 0);

        // Pointer wrap: ten push/pop pairs with one word in flight
        for (int i = 0; i < 10; i++) begin
            step(1, i[7:0], 0);
            step(0, 8'h00, 1);
        end
        step(0, 8'h00, 0);

        // Simultaneous wen+ren with 2 entries, from empty, and from full
        step(1, 8'hB0, 0);
        step(1, 8'hB1, 0);
        step(1, 8'hB2, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        step(1, 8'hC0, 1);
        step(0, 8'h00, 0);
        @(negedge clk);
        chk("empty_wr_rdata", {24'd0, rdata}, 8'hC0);
        step(1, 8'hC1, 0);
        step(1, 8'hC2, 0);
        step(1, 8'hC3, 0);
        step(1, 8'hDD, 1);
        step(0, 8'h00, 0);
        @(negedge clk);
        chk("full_wr_count", {29'd0, count}, 3);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, 8'($urandom),
                 ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        @(negedge clk);
        chk("final_empty", {29'd0, count}, 0);

        // Increment ROM sweep
        for (int d = 0; d < 4; d++) begin
            rom_d = d[1:0];
            #1;
            chk("rom_q", {30'd0, rom_q}, (d + 1) % 4);
            chk("rom_c", {31'd0, rom_c}, (d == 3) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
